// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO beats of DATA_WIDTH into one word with keep/last.
// Define STREAM_PACKER_CNT_EN to add the 16-bit word_cnt transfer counter output.

module stream_packer_lane #(
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] beat,
  input  logic                  asm_wr,
  input  logic                  asm_clr,
  input  logic                  out_ld,
  output logic [DATA_WIDTH-1:0] asm_q,
  output logic                  asm_keep,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_keep
);

  // Lanes above the write pointer stay zero, so the output word needs no masking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q    <= '0;
      asm_keep <= 1'b0;
      out_q    <= '0;
      out_keep <= 1'b0;
    end else begin
      if (out_ld) begin
        out_q    <= sel ? beat : asm_q;
        out_keep <= sel | asm_keep;
      end
      if (asm_clr) begin
        asm_q    <= '0;
        asm_keep <= 1'b0;
      end else if (asm_wr) begin
        asm_q    <= beat;
        asm_keep <= 1'b1;
      end
    end
  end

endmodule

module stream_packer #(
  parameter int DATA_WIDTH = 7,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       up_bus,
  input  logic                        up_val,
  input  logic                        up_last,
  output logic                        up_rdy,
  output logic [DATA_WIDTH*RATIO-1:0] dn_bus,
  output logic [RATIO-1:0]            dn_keep,
  output logic                        dn_last,
  output logic                        dn_val,
  input  logic                        dn_rdy
`ifdef STREAM_PACKER_CNT_EN
  ,
  output logic [15:0]                 word_cnt
`endif
);

  localparam int IW = $clog2(RATIO);

  logic [IW-1:0]                        idx;
  logic                                 acc_full;
  logic                                 asm_last;
  logic [RATIO-1:0][DATA_WIDTH-1:0]     asm_bus;
  logic [RATIO-1:0][DATA_WIDTH-1:0]     out_bus;
  logic [RATIO-1:0]                     asm_keep;
  logic [RATIO-1:0]                     out_keep;
  logic [RATIO-1:0]                     sel;
  logic                                 accept;
  logic                                 complete;
  logic                                 out_free;
  logic                                 out_ld;
  logic                                 park;

  assign up_rdy   = ~acc_full & ~rst;
  assign accept   = up_val & up_rdy;
  assign complete = accept & ((idx == IW'(RATIO - 1)) | up_last);
  assign out_free = ~dn_val | dn_rdy;
  // A parked word and a fresh completing beat never coincide: up_rdy is low while parked.
  assign out_ld   = (acc_full | complete) & out_free;
  assign park     = complete & ~out_free;

  genvar k;
  generate
    for (k = 0; k < RATIO; k++) begin : g_lane
      assign sel[k] = accept & (idx == IW'(k));

      stream_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel[k]),
        .beat     (up_bus),
        .asm_wr   (sel[k] & ~out_ld),
        .asm_clr  (out_ld),
        .out_ld   (out_ld),
        .asm_q    (asm_bus[k]),
        .asm_keep (asm_keep[k]),
        .out_q    (out_bus[k]),
        .out_keep (out_keep[k])
      );
    end
  endgenerate

  assign dn_bus  = out_bus;
  assign dn_keep = out_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      acc_full <= 1'b0;
      asm_last <= 1'b0;
      dn_val   <= 1'b0;
      dn_last  <= 1'b0;
    end else if (out_ld) begin
      dn_val   <= 1'b1;
      dn_last  <= acc_full ? asm_last : up_last;
      idx      <= '0;
      acc_full <= 1'b0;
      asm_last <= 1'b0;
    end else begin
      if (dn_rdy) dn_val <= 1'b0;
      if (park) begin
        acc_full <= 1'b1;
        asm_last <= up_last;
      end else if (accept) begin
        idx <= idx + IW'(1);
      end
    end
  end

`ifdef STREAM_PACKER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  word_cnt <= '0;
    else if (dn_val & dn_rdy) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer (DATA_WIDTH=8, RATIO=4): directed vectors plus a modelled random run.
module tb_stream_packer;

  typedef struct packed {
    logic [31:0] bus;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  up_bus = '0;
  logic        up_val = 1'b0;
  logic        up_last = 1'b0;
  logic        up_rdy;
  logic [31:0] dn_bus;
  logic [3:0]  dn_keep;
  logic        dn_last;
  logic        dn_val;
  logic        dn_rdy = 1'b0;
`ifdef STREAM_PACKER_CNT_EN
  logic [15:0] word_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  word_t sb[$];

  stream_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_bus  (up_bus),
    .up_val  (up_val),
    .up_last (up_last),
    .up_rdy  (up_rdy),
    .dn_bus  (dn_bus),
    .dn_keep (dn_keep),
    .dn_last (dn_last),
    .dn_val  (dn_val),
    .dn_rdy  (dn_rdy)
`ifdef STREAM_PACKER_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] bus, input logic [3:0] keep, input logic last);
    word_t w;
    w.bus = bus; w.keep = keep; w.last = last;
    sb.push_back(w);
  endtask

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    up_bus = d; up_last = l; up_val = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = up_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    up_val = 1'b0; up_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks held words stay put.
  logic        hold = 1'b0;
  logic [31:0] h_bus;
  logic [3:0]  h_keep;
  logic        h_last;
  always @(negedge clk) begin
    if (rst) begin
      hold  = 1'b0;
      xfers = 0;
    end else begin
      if (hold) begin
        check("hold_val",  {63'd0, dn_val}, 64'd1);
        check("hold_bus",  {32'd0, dn_bus}, {32'd0, h_bus});
        check("hold_keep", {60'd0, dn_keep}, {60'd0, h_keep});
        check("hold_last", {63'd0, dn_last}, {63'd0, h_last});
      end
      if (dn_val && dn_rdy) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h keep %0h with empty scoreboard", dn_bus, dn_keep);
        end else begin
          word_t w;
          w = sb.pop_front();
          check("word_bus",  {32'd0, dn_bus}, {32'd0, w.bus});
          check("word_keep", {60'd0, dn_keep}, {60'd0, w.keep});
          check("word_last", {63'd0, dn_last}, {63'd0, w.last});
        end
        xfers++;
      end
      hold   = dn_val && !dn_rdy;
      h_bus  = dn_bus;
      h_keep = dn_keep;
      h_last = dn_last;
    end
  end

  logic [31:0] m_bus;
  logic [3:0]  m_keep;
  int          m_idx;
  bit          rand_done;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_dn_val",  {63'd0, dn_val}, 64'd0);
    check("rst_up_rdy",  {63'd0, up_rdy}, 64'd0);
    check("rst_dn_keep", {60'd0, dn_keep}, 64'd0);
    check("rst_dn_bus",  {32'd0, dn_bus}, 64'd0);
    check("rst_dn_last", {63'd0, dn_last}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("up_rdy_after_rst", {63'd0, up_rdy}, 64'd1);
    @(posedge clk); #1;

    // Full word, one-cycle latency
    dn_rdy = 1'b1;
    expect_word(32'h44332211, 4'b1111, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("latency_dn_val", {63'd0, dn_val}, 64'd1);
    idle(2);

    // Early close with up_last
    expect_word(32'h0000BBAA, 4'b0011, 1'b1);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    idle(2);

    // Single-lane packet
    expect_word(32'h000000EE, 4'b0001, 1'b1);
    send(8'hEE, 1'b1);
    idle(2);

    // Backpressure: second word parks, up_rdy falls
    dn_rdy = 1'b0;
    expect_word(32'h04030201, 4'b1111, 1'b0);
    expect_word(32'h08070605, 4'b1111, 1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("bp_up_rdy_low", {63'd0, up_rdy}, 64'd0);
    check("bp_held_bus",   {32'd0, dn_bus}, 64'h04030201);
    dn_rdy = 1'b1;
    idle(3);
    check("bp_up_rdy_back", {63'd0, up_rdy}, 64'd1);

    // Reset mid-operation discards held and partial words
    dn_rdy = 1'b0;
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    send(8'hD1, 1'b0); send(8'hD2, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_dn_val", {63'd0, dn_val}, 64'd0);
    check("midrst_up_rdy", {63'd0, up_rdy}, 64'd0);
    idle(2);
    rst = 1'b0;
    dn_rdy = 1'b1;
    expect_word(32'h88776655, 4'b1111, 1'b0);
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    idle(3);

    // Random traffic against a packing model
    m_bus = '0; m_keep = '0; m_idx = 0; rand_done = 0;
    fork
      begin
        for (int b = 0; b < 400; b++) begin
          logic [7:0] d;
          logic l;
          d = 8'($urandom);
          l = ($urandom_range(0, 3) == 0);
          idle($urandom_range(0, 2));
          send(d, l);
          m_bus[m_idx*8 +: 8] = d;
          m_keep[m_idx] = 1'b1;
          if (m_idx == 3 || l) begin
            expect_word(m_bus, m_keep, l);
            m_bus = '0; m_keep = '0; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          dn_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    dn_rdy = 1'b1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) idle(1);
    idle(2);
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_dn_val", {63'd0, dn_val}, 64'd0);
`ifdef STREAM_PACKER_CNT_EN
    check("word_cnt", {48'd0, word_cnt}, 64'(xfers[15:0]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
